imem_fetch_controller: RTL and testbench
========================================

IMEM_FETCH_CONTROLLER -- requirements
Module: imem_fetch_controller

Interface
REQ-001 Parameter SIZE_INST, default 5, log2 of instruction memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, byte PC loaded on reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 redirect_valid  in  1  branch/jump redirect request, one-cycle pulse.
REQ-006 redirect_pc  in  32  target byte PC, bits [1:0] ignored.
REQ-007 out_valid  out  1  instruction available to decode.
REQ-008 out_ready  in  1  decode accepts instruction.
REQ-009 out_instr  out  32  fetched instruction word.
REQ-010 out_pc  out  32  byte PC of out_instr.
REQ-011 ld_valid  in  1  program-loader write request.
REQ-012 ld_addr  in  SIZE_INST  loader word address.
REQ-013 ld_data  in  32  loader write data.
REQ-014 ld_ready  out  1  loader write accepted this cycle.
REQ-015 imem_en  out  1  memory read strobe.
REQ-016 imem_we  out  1  memory write strobe.
REQ-017 imem_addr  out  SIZE_INST  memory word address.
REQ-018 imem_wdata  out  32  memory write data (= ld_data).
REQ-019 imem_rdata  in  32  read data, valid exactly one cycle after imem_en.

Function
REQ-020 Fetch address SHALL be pc[SIZE_INST+1:2]; pc increments by 4 per issued fetch; addresses wrap modulo 2^SIZE_INST words, pc wraps modulo 2^32.
REQ-021 Block SHALL hold a 2-entry FIFO of {instr, pc} pairs plus one in-flight read tag {pc, kill}.
REQ-022 Pop occurs when out_valid && out_ready; out_valid = FIFO non-empty; out_instr/out_pc = FIFO head.
REQ-023 Fetch issue (imem_en=1, imem_we=0) SHALL occur iff state is FETCH, no loader grant, no redirect this cycle, and count + inflight - pop < 2.
REQ-024 Returned data SHALL be written into the FIFO at the end of the cycle after issue unless its kill bit is set; sustained throughput 1 instruction/cycle with out_ready=1.
REQ-025 FSM states: FETCH, LOAD. FETCH->LOAD when ld_valid=1; LOAD->FETCH when ld_valid=0.
REQ-026 Loader SHALL have priority over fetch: in any cycle with ld_valid=1 and no read in flight, ld_ready=1, imem_we=1, imem_en=0, imem_addr=ld_addr; if a read is in flight, ld_ready=0 that cycle.
REQ-027 On entry to LOAD the FIFO SHALL be flushed and pc retained; no fetch issues while in LOAD.
REQ-028 On redirect_valid: pc <= {redirect_pc[31:2],2'b00}, FIFO flushed, any in-flight read marked kill, no fetch that cycle; a pop in the same cycle SHALL still count as consumed.
REQ-029 Latency: redirect in cycle R -> first fetch at R+1 -> out_valid at R+3 with out_pc = redirect target.
REQ-030 Redirect and loader in the same cycle SHALL both take effect (pc updated, write performed if granted).
REQ-031 out_valid SHALL not drop nor out_instr/out_pc change while out_valid=1 and out_ready=0, except on redirect or entry to LOAD.

Reset
REQ-032 During rst_n=0: pc=RESET_PC, FIFO empty, in-flight cleared, state FETCH, out_valid=0, ld_ready=0, imem_en=0, imem_we=0.
REQ-033 First fetch SHALL issue in the first cycle after rst_n deasserts; out_valid rises 2 cycles later.
REQ-034 Reset asserted mid-operation SHALL discard FIFO contents, in-flight read and loader transaction immediately.

Verification
REQ-035 Reset release, memory word k = k, out_ready=1 -> out_valid at cycle 2, out_pc 0,4,8,... one per cycle, instr 0,1,2,...
REQ-036 SIZE_INST=5, run 40 instructions -> out_pc 0x80 returns instr of word 0 (address wrap).
REQ-037 out_ready=0 for 5 cycles after first out_valid -> exactly 2 entries buffered, imem_en=0, head stable; release -> no loss or duplicate.
REQ-038 redirect_valid with redirect_pc=0x43 while read in flight -> killed data never appears; out_valid at R+3 with out_pc=0x40.
REQ-039 ld_valid for 3 writes (addr 0..2, data 0xA..0xC), then redirect to 0 -> ld_ready per accepted beat, no fetch during LOAD, subsequent instrs 0xA,0xB,0xC.
REQ-040 rst_n asserted while FIFO full and loader active -> outputs per REQ-032 asynchronously, restart per REQ-033.

Source files
------------

// File: rtl/imem_fetch_controller.sv
// imem_fetch_controller: instruction fetch with 2-entry output FIFO, redirect and loader write port
module imem_fetch_controller #(
    parameter int          SIZE_INST = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_pc,
    input  logic                 ld_valid,
    input  logic [SIZE_INST-1:0] ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 ld_ready,
    output logic                 imem_en,
    output logic                 imem_we,
    output logic [SIZE_INST-1:0] imem_addr,
    output logic [31:0]          imem_wdata,
    input  logic [31:0]          imem_rdata
);
    typedef enum logic {FETCH, LOAD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_q, rd_d;
    logic        inflight_q;
    logic [31:0] tag_pc_q;
    logic [31:0] instr_q [2];
    logic [31:0] ipc_q [2];
    logic        ld_grant, issue, pop, push, flush, wr;

    always_comb begin
        out_valid = count_q != 2'd0;
        pop       = out_valid && out_ready;
        ld_grant  = rst_n && ld_valid && !inflight_q;
        // Data returning while redirecting or entering LOAD is the killed read
        flush     = redirect_valid || (state_q == FETCH && ld_valid);
        push      = inflight_q && state_q == FETCH && !flush;
        issue     = rst_n && state_q == FETCH && !ld_grant && !redirect_valid
                    && (3'(count_q) + 3'(inflight_q) < 3'd2 + 3'(pop));
        state_d   = ld_valid ? LOAD : FETCH;
        pc_d      = redirect_valid ? {redirect_pc[31:2], 2'b00} : issue ? pc_q + 32'd4 : pc_q;
        count_d   = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        rd_d      = flush ? 1'b0 : rd_q ^ pop;
        wr        = rd_q ^ count_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            rd_q       <= 1'b0;
            inflight_q <= 1'b0;
            tag_pc_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            inflight_q <= issue;
            if (issue) tag_pc_q <= pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr] <= imem_rdata;
            ipc_q[wr]   <= tag_pc_q;
        end
    end

    assign out_instr  = instr_q[rd_q];
    assign out_pc     = ipc_q[rd_q];
    assign ld_ready   = ld_grant;
    assign imem_en    = issue;
    assign imem_we    = ld_grant;
    assign imem_addr  = ld_grant ? ld_addr : pc_q[SIZE_INST+1:2];
    assign imem_wdata = ld_data;
endmodule

// File: tb/tb_imem_fetch_controller.sv
// tb_imem_fetch_controller: directed stimulus with a program-order reference model of the fetch stream
module tb_imem_fetch_controller;
    logic        clk = 1'b0;
    logic        rst_n, redirect_valid, out_valid, out_ready, ld_valid, ld_ready;
    logic        imem_en, imem_we;
    logic [31:0] redirect_pc, out_instr, out_pc, ld_data, imem_wdata, imem_rdata;
    logic [4:0]  ld_addr, imem_addr;

    logic [31:0] mem [32];
    logic [31:0] img [32];
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_pc, hold_pc, hold_instr, h;
    logic        hold;
    int          beats;

    imem_fetch_controller #(.SIZE_INST(5), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: consumed instructions follow program order from the last reset/redirect target
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 32'h0;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_pc", out_pc, hold_pc);
                chk("hold_instr", out_instr, hold_instr);
            end
            if (out_valid && out_ready) begin
                chk("pop_pc", out_pc, exp_pc);
                chk("pop_instr", out_instr, img[exp_pc[6:2]]);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            hold       = out_valid && !out_ready && !redirect_valid && !ld_valid;
            hold_pc    = out_pc;
            hold_instr = out_instr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            mem[k] = 32'(k);
            img[k] = 32'(k);
        end
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ld_valid = 1'b0; ld_addr = 5'd0; ld_data = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
        ld_valid = 1'b1;
        #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        ld_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("start_en", 32'(imem_en), 32'd1);
        chk("start_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        chk("start_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("start_c2_valid", 32'(out_valid), 32'd1);
        chk("start_c2_pc", out_pc, 32'h0);
        chk("start_c2_instr", out_instr, 32'h0);
        for (int i = 0; i < 60 && !(out_valid && out_pc == 32'h80); i++) @(negedge clk);
        chk("wrap_pc", out_pc, 32'h80);
        chk("wrap_instr", out_instr, 32'h0);

        @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_en", 32'(imem_en), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        h = out_pc;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("rel0_pc", out_pc, h);
        @(negedge clk);
        chk("rel1_pc", out_pc, h + 32'd4);
        @(negedge clk);
        chk("rel2_valid", 32'(out_valid), 32'd1);
        chk("rel2_pc", out_pc, h + 32'd8);

        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h43;
        @(negedge clk);
        chk("r0_en", 32'(imem_en), 32'd0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("r1_valid", 32'(out_valid), 32'd0);
        chk("r1_en", 32'(imem_en), 32'd1);
        chk("r1_addr", 32'(imem_addr), 32'h10);
        @(negedge clk);
        chk("r2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("r3_valid", 32'(out_valid), 32'd1);
        chk("r3_pc", out_pc, 32'h40);
        chk("r3_instr", out_instr, 32'h10);

        repeat (3) @(negedge clk);
        @(posedge clk); #1 ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hA;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) chk("ld0_ready", 32'(ld_ready), 32'd0);
            else begin
                chk("ld_en", 32'(imem_en), 32'd0);
                chk("ld_out_valid", 32'(out_valid), 32'd0);
            end
            if (ld_ready) begin
                chk("ld_we", 32'(imem_we), 32'd1);
                chk("ld_addr", 32'(imem_addr), 32'(ld_addr));
                img[ld_addr] = ld_data;
                beats++;
            end
            if (beats == 3) break;
            @(posedge clk); #1 ld_addr = 5'(beats); ld_data = 32'hA + 32'(beats);
        end
        chk("ld_beats", 32'(beats), 32'd3);
        @(posedge clk); #1 ld_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        chk("lr0_en", 32'(imem_en), 32'd0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("lr1_en", 32'(imem_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("lr3_valid", 32'(out_valid), 32'd1);
        chk("lr3_instr", out_instr, 32'hA);
        @(negedge clk);
        chk("lr4_instr", out_instr, 32'hB);
        @(negedge clk);
        chk("lr5_instr", out_instr, 32'hC);

        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1 ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEAD;
        @(negedge clk);
        chk("mr_ld_ready", 32'(ld_ready), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_en", 32'(imem_en), 32'd0);
        chk("mr_we", 32'(imem_we), 32'd0);
        chk("mr_ld_ready0", 32'(ld_ready), 32'd0);
        @(posedge clk); #1 ld_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_start_en", 32'(imem_en), 32'd1);
        @(negedge clk);
        chk("mr_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mr_c2_valid", 32'(out_valid), 32'd1);
        chk("mr_c2_pc", out_pc, 32'h0);
        chk("mr_c2_instr", out_instr, 32'hA);
        repeat (8) @(negedge clk);
        chk("mr_mem5", mem[5], 32'd5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
